// File: rtl/dp_ram_port_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dp_ram_arb_pkg : shared types and helpers for dp_ram_port_arbiter          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package dp_ram_arb_pkg;

   localparam int MAX_NUM_REQ = 8;

   typedef enum logic [0:0] {
      ARB_INIT = 1'b0,
      ARB_RUN  = 1'b1
   } arb_state_e;

   function automatic int calc_id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_port_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dp_ram_port_arbiter_if : requester and dp_ram side signals of the arbiter  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface dp_ram_port_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64
);
   import dp_ram_arb_pkg::*;

   localparam int ID_WIDTH = calc_id_width(NUM_REQ);

   logic [NUM_REQ-1:0]            rd_req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr;
   logic [NUM_REQ-1:0]            rd_req_ready;
   logic [NUM_REQ-1:0]            wr_req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wr_req_data;
   logic [NUM_REQ*DATA_WIDTH-1:0] wr_req_mask;
   logic [NUM_REQ-1:0]            wr_req_ready;
   logic                          rd_rsp_valid;
   logic [ID_WIDTH-1:0]           rd_rsp_id;
   logic [DATA_WIDTH-1:0]         rd_rsp_data;
   logic                          ram_rd_en;
   logic [ADDR_WIDTH-1:0]         ram_rd_addr;
   logic                          ram_wr_en;
   logic [ADDR_WIDTH-1:0]         ram_wr_addr;
   logic [DATA_WIDTH-1:0]         ram_data_in;
   logic [DATA_WIDTH-1:0]         ram_mask_in;
   logic [DATA_WIDTH-1:0]         ram_data_out;

   modport slave (
      input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
             wr_req_data, wr_req_mask, ram_data_out,
      output rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
             ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_data_in, ram_mask_in
   );

   modport master (
      output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr,
             wr_req_data, wr_req_mask, ram_data_out,
      input  rd_req_ready, wr_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
             ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_data_in, ram_mask_in
   );

endinterface
`default_nettype wire

// File: rtl/dp_ram_port_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant, pointer moves past winner on en_i  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o
);
   localparam int PW = (N <= 2) ? 1 : $clog2(N);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win;
   logic          found;

   // Scan from ptr_q upward with wrap; an extra bit keeps the sum exact for non-power-of-2 N.
   always_comb begin : p_grant
      logic [PW:0] c;
      gnt_o = '0;
      win   = ptr_q;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         c = {1'b0, ptr_q} + (PW+1)'(k);
         if (c >= (PW+1)'(N)) c = c - (PW+1)'(N);
         if (!found && req_i[c[PW-1:0]]) begin
            found             = 1'b1;
            gnt_o[c[PW-1:0]]  = 1'b1;
            win               = c[PW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (en_i && found) ptr_d = (win == PW'(N-1)) ? '0 : win + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/dp_ram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dp_ram_port_arbiter : shares one dp_ram read/write port pair among NUM_REQ |
// | requesters. Define DP_RAM_ARB_RAW_BYPASS_EN to forward colliding writes.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module dp_ram_port_arbiter
   import dp_ram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int INIT_WAIT  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dp_ram_port_arbiter_if.slave  bus,
   output logic                  init_done_o
);
   localparam int         ID_WIDTH  = calc_id_width(NUM_REQ);
   localparam arb_state_e RST_STATE = (INIT_WAIT != 0) ? ARB_INIT : ARB_RUN;

   if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
      $error("dp_ram_port_arbiter: NUM_REQ out of range");
   end

   arb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ARB_INIT) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (&cnt_q) state_d = ARB_RUN;
      end
   end

   always_comb begin
      run         = (state_q == ARB_RUN);
      init_done_o = run;
   end

   logic [NUM_REQ-1:0]    rd_gnt, wr_gnt;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic [DATA_WIDTH-1:0] wr_data, wr_mask;
   logic [ID_WIDTH-1:0]   rd_id;
   logic                  collide, rd_fire, wr_fire;

   rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
      .clk(clk), .rst_n(rst_n), .req_i(bus.rd_req_valid & {NUM_REQ{run}}),
      .en_i(rd_fire), .gnt_o(rd_gnt)
   );

   rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
      .clk(clk), .rst_n(rst_n), .req_i(bus.wr_req_valid & {NUM_REQ{run}}),
      .en_i(wr_fire), .gnt_o(wr_gnt)
   );

   always_comb begin
      rd_addr = '0;
      rd_id   = '0;
      wr_addr = '0;
      wr_data = '0;
      wr_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rd_gnt[i]) begin
            rd_addr = bus.rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rd_id   = ID_WIDTH'(i);
         end
         if (wr_gnt[i]) begin
            wr_addr = bus.wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data = bus.wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            wr_mask = bus.wr_req_mask[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign collide = (|rd_gnt) && (|wr_gnt) && (rd_addr == wr_addr);
   assign wr_fire = |wr_gnt;
`ifdef DP_RAM_ARB_RAW_BYPASS_EN
   assign rd_fire = |rd_gnt;
`else
   // Write wins a same-address collision; the read pointer stays so the reader retries next.
   assign rd_fire = (|rd_gnt) && !collide;
`endif

   assign bus.rd_req_ready = rd_fire ? rd_gnt : '0;
   assign bus.wr_req_ready = wr_gnt;
   assign bus.ram_rd_en    = rd_fire;
   assign bus.ram_rd_addr  = rd_addr;
   assign bus.ram_wr_en    = wr_fire;
   assign bus.ram_wr_addr  = wr_addr;
   assign bus.ram_data_in  = wr_data;
   assign bus.ram_mask_in  = wr_mask;

   logic                rsp_valid_q;
   logic [ID_WIDTH-1:0] rsp_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         rsp_valid_q <= rd_fire;
         if (rd_fire) rsp_id_q <= rd_id;
      end
   end

   assign bus.rd_rsp_valid = rsp_valid_q;
   assign bus.rd_rsp_id    = rsp_id_q;

`ifdef DP_RAM_ARB_RAW_BYPASS_EN
   logic [DATA_WIDTH-1:0] byp_data_q, byp_mask_q;

   // The RAM reads old data on a collision, so the masked write bits are merged on the response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_data_q <= '0;
         byp_mask_q <= '0;
      end else if (rd_fire) begin
         byp_data_q <= wr_data;
         byp_mask_q <= collide ? wr_mask : '0;
      end
   end

   assign bus.rd_rsp_data = (byp_data_q & byp_mask_q) | (bus.ram_data_out & ~byp_mask_q);
`else
   assign bus.rd_rsp_data = bus.ram_data_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_dp_ram_port_arbiter : directed and random checks against a shadow model |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_dp_ram_port_arbiter;
   localparam int NR    = 3;
   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done;
   always #5 clk = ~clk;

   dp_ram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dp_ram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_WAIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .init_done_o(init_done)
   );

   // Read-first RAM that zero-fills while reset is held.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         bus.ram_data_out <= '0;
      end else begin
         if (bus.ram_rd_en) bus.ram_data_out <= mem[bus.ram_rd_addr];
         if (bus.ram_wr_en)
            mem[bus.ram_wr_addr] <= (mem[bus.ram_wr_addr] & ~bus.ram_mask_in) |
                                    (bus.ram_data_in & bus.ram_mask_in);
      end
   end

   logic [NR-1:0] rv, wv;
   logic [AW-1:0] ra [NR];
   logic [AW-1:0] wa [NR];
   logic [DW-1:0] wd [NR];
   logic [DW-1:0] wm [NR];

   int            ncmp, nfail, rptr, wptr, edges, pend_id;
   bit            run_m, pend_v, rnd_mode, hold_rd;
   logic [DW-1:0] shadow [DEPTH];
   logic [DW-1:0] pend_d;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++) begin
         int i;
         i = (ptr + k) % NR;
         if (((v >> i) & NR'(1)) != '0) return i;
      end
      return -1;
   endfunction

   task automatic drive();
      bus.rd_req_valid = rv;
      bus.wr_req_valid = wv;
      for (int i = 0; i < NR; i++) begin
         bus.rd_req_addr[i*AW +: AW] = ra[i];
         bus.wr_req_addr[i*AW +: AW] = wa[i];
         bus.wr_req_data[i*DW +: DW] = wd[i];
         bus.wr_req_mask[i*DW +: DW] = wm[i];
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pend_v = 0; rptr = 0; wptr = 0; edges = 0; run_m = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_ready", bus.rd_req_ready, '0);
      check("rst_wr_ready", bus.wr_req_ready, '0);
      check("rst_ram_en", {bus.ram_rd_en, bus.ram_wr_en}, '0);
      check("rst_rsp_valid", bus.rd_rsp_valid, '0);
      check("rst_rsp_id", bus.rd_rsp_id, '0);
      check("rst_init_done", init_done, '0);
      rst_n = 1'b1;
   endtask

   // One clock of checking against the model, then requester updates.
   task automatic step();
      int r, w;
      bit col;
      @(negedge clk);
      check("init_done", init_done, run_m);
      check("rsp_valid", bus.rd_rsp_valid, pend_v);
      if (pend_v) begin
         check("rsp_id", bus.rd_rsp_id, pend_id);
         check("rsp_data", bus.rd_rsp_data, pend_d);
      end
      r = -1; w = -1;
      if (run_m) begin
         r = pick(rv, rptr);
         w = pick(wv, wptr);
      end
      col = (r >= 0) && (w >= 0) && (ra[r] == wa[w]);
`ifndef DP_RAM_ARB_RAW_BYPASS_EN
      if (col) r = -1;
`endif
      check("rd_ready", bus.rd_req_ready, (r >= 0) ? (NR'(1) << r) : '0);
      check("wr_ready", bus.wr_req_ready, (w >= 0) ? (NR'(1) << w) : '0);
      check("ram_rd_en", bus.ram_rd_en, r >= 0);
      check("ram_wr_en", bus.ram_wr_en, w >= 0);
      if (r >= 0) check("ram_rd_addr", bus.ram_rd_addr, ra[r]);
      if (w >= 0) begin
         check("ram_wr_addr", bus.ram_wr_addr, wa[w]);
         check("ram_data_in", bus.ram_data_in, wd[w]);
         check("ram_mask_in", bus.ram_mask_in, wm[w]);
         shadow[wa[w]] = (shadow[wa[w]] & ~wm[w]) | (wd[w] & wm[w]);
         wptr = (w + 1) % NR;
      end
      pend_v = (r >= 0);
      if (r >= 0) begin
         pend_id = r;
         pend_d  = shadow[ra[r]];
         rptr    = (r + 1) % NR;
      end
      @(posedge clk);
      #1;
      edges++;
      if (edges >= 16) run_m = 1;
      if (r >= 0 && (rnd_mode || !hold_rd)) rv = rv & ~(NR'(1) << r);
      if (w >= 0) wv = wv & ~(NR'(1) << w);
      if (rnd_mode) begin
         for (int i = 0; i < NR; i++) begin
            if (((rv >> i) & NR'(1)) == '0 && $urandom_range(0, 1) == 1) begin
               rv    = rv | (NR'(1) << i);
               ra[i] = AW'($urandom_range(0, 3));
            end
            if (((wv >> i) & NR'(1)) == '0 && $urandom_range(0, 2) == 0) begin
               wv    = wv | (NR'(1) << i);
               wa[i] = AW'($urandom_range(0, 3));
               wd[i] = DW'($urandom);
               wm[i] = DW'($urandom);
            end
         end
      end
      drive();
   endtask

   initial begin
      ncmp = 0; nfail = 0; rnd_mode = 0; hold_rd = 1;
      rv = '1; wv = '0;
      for (int i = 0; i < NR; i++) begin
         ra[i] = AW'(i + 1); wa[i] = '0; wd[i] = '0; wm[i] = '0;
      end
      drive();
      do_reset();

      // Init sweep with reads pending, then continuous round-robin rotation.
      repeat (16) step();
      repeat (6) step();
      rv = '0; drive();
      step();

      // Masked write then read-back.
      wv = 3'b001; wa[0] = 4'h5; wd[0] = 16'hFFFF; wm[0] = 16'h000F; drive();
      step();
      hold_rd = 0;
      rv = 3'b100; ra[2] = 4'h5; drive();
      step();
      step();

      // Same-address read/write collision.
      wv = 3'b001; wa[0] = 4'h7; wd[0] = 16'hA5A5; wm[0] = 16'h0FF0;
      rv = 3'b010; ra[1] = 4'h7; drive();
      repeat (3) step();

      // Reset while a response is pending.
      rv = 3'b010; ra[1] = 4'h3; drive();
      step();
      rst_n = 1'b0;
      #1;
      check("rst_drop_rsp", bus.rd_rsp_valid, '0);
      check("rst_drop_ready", bus.rd_req_ready, '0);
      rv = '1; wv = '1;
      for (int i = 0; i < NR; i++) begin
         ra[i] = AW'(i); wa[i] = AW'(i + 1); wd[i] = DW'(16'h1111 * (i + 1)); wm[i] = '1;
      end
      drive();
      do_reset();
      repeat (20) step();

      rnd_mode = 1;
      repeat (400) step();
      rv = '0; wv = '0; drive();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
